// File: rtl/uart_report_pkg.sv
// Shared definitions for the UART report generator: select codes, ASCII constants, message lengths.
// Build option: define REPORT_CRLF_EN to end each report with CR LF instead of a bare LF.
package uart_report_pkg;

    typedef enum logic [1:0] {
        SEL_TIME = 2'd0,
        SEL_DIST = 2'd1,
        SEL_DHT  = 2'd2,
        SEL_RSVD = 2'd3
    } sel_e;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] distance;
        logic [7:0] hum_int;
        logic [7:0] hum_dec;
        logic [7:0] tmp_int;
        logic [7:0] tmp_dec;
    } report_vals_t;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_D     = 8'h44;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;

    // Payload lengths exclude the end-of-line bytes
    localparam int unsigned PAY_TIME = 8;
    localparam int unsigned PAY_DIST = 5;
    localparam int unsigned PAY_DHT  = 13;

    localparam int unsigned LEN_TIME_CRLF = 10;
    localparam int unsigned LEN_DIST_CRLF = 7;
    localparam int unsigned LEN_DHT_CRLF  = 15;
    localparam int unsigned LEN_TIME_LF   = 9;
    localparam int unsigned LEN_DIST_LF   = 6;
    localparam int unsigned LEN_DHT_LF    = 14;

`ifdef REPORT_CRLF_EN
    localparam bit CRLF_EN = 1'b1;
`else
    localparam bit CRLF_EN = 1'b0;
`endif

    function automatic int unsigned pay_len(input sel_e sel);
        case (sel)
            SEL_TIME: return PAY_TIME;
            SEL_DIST: return PAY_DIST;
            SEL_DHT:  return PAY_DHT;
            default:  return 0;
        endcase
    endfunction

    function automatic int unsigned msg_len(input sel_e sel, input bit crlf);
        case (sel)
            SEL_TIME: return crlf ? LEN_TIME_CRLF : LEN_TIME_LF;
            SEL_DIST: return crlf ? LEN_DIST_CRLF : LEN_DIST_LF;
            SEL_DHT:  return crlf ? LEN_DHT_CRLF  : LEN_DHT_LF;
            default:  return 1;
        endcase
    endfunction

endpackage

// File: rtl/uart_report_gen_if.sv
// Request/value inputs and TX FIFO write side of the report generator.
interface uart_report_gen_if;
    import uart_report_pkg::*;

    logic         start;
    sel_e         sel;
    report_vals_t vals;
    logic         tx_full;
    logic [7:0]   tx_data;
    logic         tx_we;
    logic         busy;
    logic         done;

    modport master (
        output start, sel, vals, tx_full,
        input  tx_data, tx_we, busy, done
    );

    modport slave (
        input  start, sel, vals, tx_full,
        output tx_data, tx_we, busy, done
    );
endinterface

// File: rtl/bin2dec3.sv
// Combinational 8-bit binary to three decimal digits.
module bin2dec3 (
    input  logic [7:0] bin,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    assign hundreds = 4'(bin / 8'd100);
    assign tens     = 4'((bin / 8'd10) % 8'd10);
    assign ones     = 4'(bin % 8'd10);
endmodule

// File: rtl/uart_report_gen.sv
// Formats a time, distance or humidity/temperature snapshot as an ASCII line into a TX FIFO.
// End-of-line is CR LF when REPORT_CRLF_EN is defined, LF otherwise.
module uart_report_gen
    import uart_report_pkg::*;
#(
    parameter int unsigned MSG_MAX = 15
) (
    input logic              clk,
    input logic              rst,
    uart_report_gen_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(MSG_MAX + 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

    state_e             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    sel_e               snap_sel;
    report_vals_t       snap;
    logic               load;
    logic               we;
    logic               last;
    logic [7:0]         pos;
    logic [7:0]         pay;
    logic [7:0]         fval;
    logic [3:0]         d_h, d_t, d_o;
    logic [7:0]         cur;

    assign last = (idx == IDX_W'(msg_len(snap_sel, CRLF_EN) - 1));
    assign pos  = 8'(idx);
    assign pay  = 8'(pay_len(snap_sel));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            snap_sel <= SEL_TIME;
            snap     <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (load) begin
                snap_sel <= bus.sel;
                snap     <= bus.vals;
            end
        end
    end

    // Index advances only on an actual FIFO write, so a full FIFO simply replays the same byte
    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        we      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && bus.sel != SEL_RSVD) begin
                    state_n = SEND;
                    idx_n   = '0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (!bus.tx_full) begin
                    we = 1'b1;
                    if (last) begin
                        state_n = DONE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pick the field whose digits the current byte position needs
    always_comb begin
        fval = 8'h00;
        case (snap_sel)
            SEL_TIME: begin
                case (pos)
                    8'd0, 8'd1: fval = snap.hour;
                    8'd3, 8'd4: fval = snap.min;
                    8'd6, 8'd7: fval = snap.sec;
                    default: ;
                endcase
            end
            SEL_DIST: fval = snap.distance;
            SEL_DHT: begin
                case (pos)
                    8'd2, 8'd3:  fval = snap.hum_int;
                    8'd5:        fval = snap.hum_dec;
                    8'd9, 8'd10: fval = snap.tmp_int;
                    8'd12:       fval = snap.tmp_dec;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    bin2dec3 u_bin2dec3 (
        .bin      (fval),
        .hundreds (d_h),
        .tens     (d_t),
        .ones     (d_o)
    );

    function automatic logic [7:0] asc(input logic [3:0] d);
        return ASCII_0 + {4'h0, d};
    endfunction

    always_comb begin
        cur = ASCII_LF;
        if (pos >= pay) begin
            if (CRLF_EN && pos == pay) cur = ASCII_CR;
        end else begin
            case (snap_sel)
                SEL_TIME: begin
                    case (pos)
                        8'd0, 8'd3, 8'd6: cur = asc(d_t);
                        8'd1, 8'd4, 8'd7: cur = asc(d_o);
                        default:          cur = ASCII_COLON;
                    endcase
                end
                SEL_DIST: begin
                    case (pos)
                        8'd0:    cur = ASCII_D;
                        8'd1:    cur = ASCII_EQ;
                        8'd2:    cur = asc(d_h);
                        8'd3:    cur = asc(d_t);
                        default: cur = asc(d_o);
                    endcase
                end
                SEL_DHT: begin
                    case (pos)
                        8'd0:        cur = ASCII_H;
                        8'd1, 8'd8:  cur = ASCII_EQ;
                        8'd2, 8'd9:  cur = asc(d_t);
                        8'd4, 8'd11: cur = ASCII_DOT;
                        8'd6:        cur = ASCII_SP;
                        8'd7:        cur = ASCII_T;
                        default:     cur = asc(d_o);
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_we   = we;
    assign bus.tx_data = (state == SEND) ? cur : 8'h00;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_uart_report_gen.sv
// Self-checking bench for uart_report_gen: table of reports plus stall, ignored-start and reset sequences.
module tb_uart_report_gen;
    import uart_report_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_report_gen_if bus ();

    uart_report_gen #(.MSG_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        sel_e         sel;
        report_vals_t v;
        string        pay;
    } vec_t;

    int         checks   = 0;
    int         errors   = 0;
    int         nbytes   = 0;
    int         done_cnt = 0;
    logic [7:0] sb_q[$];
    vec_t       vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic report_vals_t mk(input int h, input int m, input int s, input int d,
                                        input int hi, input int hd, input int ti, input int td);
        report_vals_t r;
        r.hour = 8'(h); r.min = 8'(m); r.sec = 8'(s); r.distance = 8'(d);
        r.hum_int = 8'(hi); r.hum_dec = 8'(hd); r.tmp_int = 8'(ti); r.tmp_dec = 8'(td);
        return r;
    endfunction

    function automatic int eol_len();
`ifdef REPORT_CRLF_EN
        return 2;
`else
        return 1;
`endif
    endfunction

    task automatic push_msg(input string pay);
        for (int i = 0; i < pay.len(); i++) sb_q.push_back(8'(pay.getc(i)));
`ifdef REPORT_CRLF_EN
        sb_q.push_back(8'h0D);
`endif
        sb_q.push_back(8'h0A);
    endtask

    // Scoreboard side: every FIFO write must match the oldest expected byte
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.done) done_cnt++;
            if (bus.tx_we) begin
                chk("we_while_full", 32'(bus.tx_full), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got %02h expected no write", bus.tx_data);
                end else begin
                    chk("tx_byte", 32'(bus.tx_data), 32'(sb_q.pop_front()));
                end
                nbytes++;
            end
        end
    end

    task automatic run_report(input sel_e sel, input report_vals_t v, input string pay,
                              input int stall_after, input int stall_len, input bit poke);
        int n0, st, exp_n;
        bit seen, stalled;
        st = 0; seen = 1'b0; stalled = 1'b0;
        exp_n = pay.len() + eol_len();
        @(posedge clk); #1;
        bus.sel = sel; bus.vals = v; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        push_msg(pay);
        n0 = nbytes;
        // Scramble inputs: the message must come from the snapshot
        bus.vals = {$urandom, $urandom};
        bus.sel  = sel_e'(2'($urandom_range(0, 3)));
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("first_we", 32'(bus.tx_we), 32'd1);
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.tx_full && sb_q.size() > 0) begin
                    chk("stall_we", 32'(bus.tx_we), 32'd0);
                    chk("stall_data", 32'(bus.tx_data), 32'(sb_q[0]));
                end
                @(posedge clk); #1;
                bus.start = 1'b0;
                if (poke && nbytes - n0 == 2) begin
                    bus.start = 1'b1;
                    bus.sel   = SEL_TIME;
                end
                if (st > 0) begin
                    st--;
                    if (st == 0) bus.tx_full = 1'b0;
                end else if (stall_after >= 0 && !stalled && nbytes - n0 == stall_after) begin
                    bus.tx_full = 1'b1;
                    st = stall_len;
                    stalled = 1'b1;
                end
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_in_done", 32'(bus.busy), 32'd1);
        chk("byte_count", 32'(nbytes - n0), 32'(exp_n));
        chk("queue_empty", 32'(sb_q.size()), 32'd0);
        if (poke) begin
            bus.start = 1'b1;
            bus.sel   = SEL_DIST;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("idle_after_done", 32'(bus.busy), 32'd0);
        if (poke) begin
            repeat (3) @(negedge clk);
            chk("no_restart", 32'(bus.busy), 32'd0);
            chk("no_restart_bytes", 32'(nbytes - n0), 32'(exp_n));
        end
    endtask

    initial begin
        int n0, d0;
        rst = 1'b1;
        bus.start = 1'b0; bus.sel = SEL_TIME; bus.vals = '0; bus.tx_full = 1'b0;

        vecs[0] = '{SEL_TIME, mk(13, 5, 59, 0, 0, 0, 0, 0),        "13:05:59"};
        vecs[1] = '{SEL_DIST, mk(0, 0, 0, 7, 0, 0, 0, 0),          "D=007"};
        vecs[2] = '{SEL_DIST, mk(0, 0, 0, 255, 0, 0, 0, 0),        "D=255"};
        vecs[3] = '{SEL_DHT,  mk(0, 0, 0, 0, 45, 0, 23, 12),       "H=45.0 T=23.2"};
        vecs[4] = '{SEL_DIST, mk(0, 0, 0, 100, 0, 0, 0, 0),        "D=100"};
        vecs[5] = '{SEL_TIME, mk(123, 200, 0, 9, 0, 0, 0, 0),      "23:00:00"};
        vecs[6] = '{SEL_DHT,  mk(0, 0, 0, 0, 99, 9, 100, 255),     "H=99.9 T=00.5"};
        vecs[7] = '{SEL_DIST, mk(1, 2, 3, 0, 4, 5, 6, 7),          "D=000"};

        repeat (2) @(negedge clk);
        chk("rst_tx_we", 32'(bus.tx_we), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_report(vecs[i].sel, vecs[i].v, vecs[i].pay, -1, 0, 1'b0);

        // FIFO full for 5 cycles after the third byte
        run_report(vecs[0].sel, vecs[0].v, vecs[0].pay, 3, 5, 1'b0);
        // start during SEND and during DONE
        run_report(vecs[1].sel, vecs[1].v, vecs[1].pay, -1, 0, 1'b1);

        // Reserved select is ignored
        @(posedge clk); #1;
        n0 = nbytes;
        bus.sel = SEL_RSVD; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("sel3_busy", 32'(bus.busy), 32'd0);
        chk("sel3_bytes", 32'(nbytes - n0), 32'd0);

        // Reset after four bytes aborts the report
        @(posedge clk); #1;
        bus.sel = SEL_DHT; bus.vals = vecs[3].v; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        push_msg(vecs[3].pay);
        n0 = nbytes;
        d0 = done_cnt;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (nbytes - n0 >= 4) break;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("bytes_before_reset", 32'(nbytes - n0), 32'd4);
        chk("abort_tx_we", 32'(bus.tx_we), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_tx_data", 32'(bus.tx_data), 32'd0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_stays_idle", 32'(bus.busy), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_no_bytes", 32'(nbytes - n0), 32'd4);

        // Normal operation after the abort
        run_report(vecs[3].sel, vecs[3].v, vecs[3].pay, -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_report_gen.md
UART_REPORT_GEN -- requirements
Module: uart_report_gen

Interface
REQ-001 Parameter MSG_MAX, default 15: longest message length in bytes; sizes the byte-index counter.
REQ-002 Port clk, input, 1: system clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port start, input, 1: one-cycle request to emit one report.
REQ-005 Port sel, input, 2: report type (0 time, 1 distance, 2 humidity/temperature, 3 reserved).
REQ-006 Ports hour, min, sec, input, 8 each: binary time values.
REQ-007 Port distance, input, 8: binary distance in cm.
REQ-008 Ports hum_int, hum_dec, tmp_int, tmp_dec, input, 8 each: DHT11 fields.
REQ-009 Port tx_full, input, 1: TX FIFO full flag.
REQ-010 Port tx_data, output, 8: ASCII byte to the TX FIFO.
REQ-011 Port tx_we, output, 1: FIFO write strobe; tx_data is valid in the same cycle.
REQ-012 Port busy, output, 1: report in progress.
REQ-013 Port done, output, 1: one-cycle pulse after the last byte is written.

Function
REQ-014 FSM states: IDLE, SEND, DONE. Transitions: IDLE->SEND on start with sel!=3; SEND->DONE after the last byte; DONE->IDLE unconditionally.
REQ-015 On accepted start, sel and all value inputs are snapshotted; input changes during SEND have no effect on the message.
REQ-016 start while busy, or start with sel=3, is ignored: no bytes are written and done is not pulsed.
REQ-017 Message formats, with d = decimal digit:
- sel=0: "hh:mm:ss" + EOL
- sel=1: "D=ddd" + EOL
- sel=2: "H=hh.d T=tt.d" + EOL
REQ-018 Digit rules:
- 2-digit fields use value%100, zero-padded.
- 3-digit fields are zero-padded (0..255).
- Decimal fields (.d) use value%10.
- Digits are encoded as 8'h30+digit.
REQ-019 In SEND, tx_we=1 exactly in cycles where tx_full=0; the byte index advances only on tx_we.
REQ-020 If tx_full=1 in SEND, tx_we=0 and tx_data holds its value; sending resumes with the same byte when tx_full falls.
REQ-021 The first tx_we can assert in the cycle after start is accepted; with tx_full held low, a message of N bytes occupies N consecutive tx_we cycles.
REQ-022 busy is high from the cycle after accepted start through the DONE cycle inclusive; done=1 only in the DONE state.
REQ-023 A start arriving in the DONE cycle is ignored; a new report may be accepted once the FSM is back in IDLE.

Reset
REQ-024 While rst=1: state IDLE, byte index 0, snapshot registers 0, tx_data=8'h00, tx_we=0, busy=0, done=0.
REQ-025 rst asserted mid-message aborts the report immediately; no further bytes are written and done is not pulsed.

Configuration
REQ-026 Macro REPORT_CRLF_EN:
- Defined: EOL = 8'h0D,8'h0A (lengths 10/7/15).
- Undefined: EOL = 8'h0A only (lengths 9/6/14).

Structure
REQ-027 Shared package uart_report_pkg holds:
- SEL encodings
- ASCII constants (':', '=', '.', ' ', 'D', 'H', 'T', CR, LF, '0')
- Per-sel message lengths under both macro settings
REQ-028 One sub-module, bin2dec3: combinational 8-bit binary to hundreds/tens/ones digits; the block instantiates it on the snapshot values.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- sel=0, hour=13, min=5, sec=59, tx_full=0 -> bytes "13:05:59\r\n" on 10 consecutive tx_we, then done 1 cycle.
- sel=1, distance=7 -> "D=007\r\n"; then distance=255 -> "D=255\r\n".
- sel=2, hum_int=45, hum_dec=0, tmp_int=23, tmp_dec=12 -> "H=45.0 T=23.2\r\n" (15 bytes).
- tx_full held high for 5 cycles after byte 3 -> no tx_we during the stall, no byte lost or duplicated, final stream identical.
- start during busy, and start with sel=3 -> ignored, zero extra bytes; rst pulsed at byte 4 -> tx_we stops, busy=0, done never pulses.
- Build without REPORT_CRLF_EN, sel=1, distance=100 -> "D=100\n", 6 bytes.
